sram_stream_reader: RTL and testbench

Read-side initiator for a single-bank synchronous SRAM with 1-cycle read latency (chip select, write enable, address; data returned on the cycle after the access). On a start command it walks a contiguous address range, issues one read per cycle when credit allows, and presents the returned words as a valid/ready stream with last-beat marking. It sits between the attention-score buffers and downstream consumers. A 2-entry buffer absorbs in-flight reads under backpressure without dropping data.

---
 rtl/sram_rd_pkg.sv | 23 ++
 rtl/sync_fifo2.sv | 51 +++++
 rtl/sram_stream_reader.sv | 106 ++++++++++
 tb/tb_sram_stream_reader.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sram_rd_pkg.sv
// Shared types and helpers for the SRAM stream reader: FSM states,
// buffer depth and the read-credit check.
package sram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

    // A new read may issue only if every word already buffered or in flight,
    // less the one leaving this cycle, still leaves a free slot.
    function automatic logic credit_ok(input logic [1:0] occ,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] pending;
        pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return pending < 3'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO; head word is presented combinationally on dout.
module sync_fifo2 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_stream_reader.sv
// Walks a contiguous SRAM address range and streams the returned words out
// over valid/ready, with credit-limited reads absorbed by a 2-entry buffer.
module sram_stream_reader
    import sram_rd_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [LEN_W-1:0]  issue_rem;
    logic [LEN_W-1:0]  beat_rem;
    logic              inflight;
    logic              issue;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [1:0]        occ;

    sync_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (sram_rdata),
        .pop   (pop),
        .dout  (m_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (occ)
    );

    assign m_valid   = !fifo_empty;
    assign pop       = m_valid && m_ready;
    assign m_last    = m_valid && (beat_rem == LEN_W'(1));
    assign issue     = (state == RUN) && (issue_rem != '0) && credit_ok(occ, inflight, pop);
    assign sram_cs   = issue;
    assign sram_we   = 1'b0;
    // Between reads the address bus parks on the last address actually issued.
    assign sram_addr = issue ? issue_addr : last_addr;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (len == '0) ? DONE : RUN;
            RUN:  if (pop && m_last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            issue_addr <= '0;
            last_addr  <= '0;
            issue_rem  <= '0;
            beat_rem   <= '0;
            inflight   <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (state == IDLE && start) begin
                issue_addr <= base_addr;
                issue_rem  <= len;
                beat_rem   <= len;
            end else begin
                if (issue) begin
                    issue_addr <= issue_addr + ADDR_W'(1);
                    issue_rem  <= issue_rem - LEN_W'(1);
                    last_addr  <= issue_addr;
                end
                if (pop)
                    beat_rem <= beat_rem - LEN_W'(1);
            end
        end
    end

    // Returning data must always find a slot unless the head leaves this cycle.
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(inflight && fifo_full && !pop));
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader: table of transfers plus a reset-mid-run sequence.
module tb_sram_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] len;
    logic        busy, done, sram_cs, sram_we;
    logic [11:0] sram_addr;
    logic [15:0] sram_rdata;
    logic        m_valid, m_last, m_ready;
    logic [15:0] m_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] base;
        logic [12:0] len;
        logic [7:0]  ready;     // m_ready pattern indexed by cycle % 8
        int          done_exp;  // expected done cycle after start, -1 = don't care
        bit          mid;       // pulse a second start while busy
    } vec_t;

    vec_t vecs[7];

    sram_stream_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .sram_cs(sram_cs), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_rdata(sram_rdata), .m_valid(m_valid),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    // SRAM model: mem[a] = a, one-cycle read latency.
    always @(posedge clk)
        if (sram_cs) sram_rdata <= {4'h0, sram_addr};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int          cyc, beats, issued, outst, done_cyc;
        logic        pv, pr, popn;
        logic [15:0] pd;
        logic [11:0] ea;
        bit          fin;
        beats = 0; issued = 0; outst = 0; done_cyc = -1; fin = 0;
        pv = 1'b0; pr = 1'b0; pd = '0;
        @(negedge clk);
        base_addr = v.base; len = v.len; start = 1'b1; m_ready = v.ready[0];
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!fin && cyc < 300) begin
            if (v.mid && cyc == 2) begin
                start = 1'b1; base_addr = 12'h500; len = 13'd9;
            end else begin
                start = 1'b0;
            end
            m_ready = v.ready[cyc % 8];
            #1;
            popn = m_valid && m_ready;
            if (cyc == 1) check("busy_after_start", busy, v.len != 0);
            if (v.ready == 8'hFF && cyc == 2) check("no_valid_cyc2", m_valid, 0);
            if (v.ready == 8'hFF && cyc == 3 && v.len != 0) check("first_valid_cyc3", m_valid, 1);
            check("we_low", sram_we, 0);
            if (sram_cs) begin
                ea = v.base + 12'(issued);
                check("addr_order", sram_addr, ea);
                check("credit", (outst - int'(popn)) < 2, 1);
            end
            if (pv && !pr) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, pd);
            end
            if (m_valid) check("last_flag", m_last, beats == int'(v.len) - 1);
            if (popn) begin
                ea = v.base + 12'(beats);
                check("beat_data", m_data, {4'h0, ea});
                beats++;
            end
            if (done) begin
                fin = 1; done_cyc = cyc;
                check("busy_at_done", busy, 0);
            end
            outst  = outst + int'(sram_cs) - int'(popn);
            issued = issued + int'(sram_cs);
            pv = m_valid; pr = m_ready; pd = m_data;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!fin) check("timeout_done", 0, 1);
        if (v.done_exp >= 0) check("done_cycle", done_cyc, v.done_exp);
        check("beat_count", beats, int'(v.len));
        check("cs_count", issued, int'(v.len));
        #1;
        check("done_one_cycle", done, 0);
        check("idle_valid", m_valid, 0);
    endtask

    initial begin
        vecs[0] = '{base: 12'h010, len: 13'd4, ready: 8'hFF,        done_exp: 7,  mid: 0};
        vecs[1] = '{base: 12'h010, len: 13'd4, ready: 8'b1001_1001, done_exp: -1, mid: 0};
        vecs[2] = '{base: 12'hFFE, len: 13'd4, ready: 8'hFF,        done_exp: 7,  mid: 0};
        vecs[3] = '{base: 12'h000, len: 13'd0, ready: 8'hFF,        done_exp: 1,  mid: 0};
        vecs[4] = '{base: 12'h100, len: 13'd5, ready: 8'hFF,        done_exp: 8,  mid: 1};
        vecs[5] = '{base: 12'h7F0, len: 13'd3, ready: 8'b0000_0001, done_exp: -1, mid: 0};
        vecs[6] = '{base: 12'h123, len: 13'd1, ready: 8'hFF,        done_exp: 4,  mid: 0};

        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cs", sram_cs, 0);
        check("rst_we", sram_we, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

        // Reset while two words sit in the buffer with the consumer stalled.
        @(negedge clk);
        base_addr = 12'h200; len = 13'd8; start = 1'b1; m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_valid", m_valid, 1);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_cs", sram_cs, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", sram_addr, 0);
        rst = 1'b0;
        run_xfer('{base: 12'h000, len: 13'd3, ready: 8'hFF, done_exp: 6, mid: 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
